// File: rtl/sp_stream_acc.sv
// Result scratchpad for the matrix-multiply datapath.
// Holds SP_NTARGETS matrix slots of MAX_DIM rows. Each row is BUS_WIDTH bits wide.
// Writes either overwrite a row or accumulate into it lane-wise.
// A registered random-read port returns one row per request.
// A valid/ready engine streams the first N rows of one slot to the bus side.

// Single-lane accumulate: signed DATA_WIDTH add, with optional clamp on overflow.
module sp_acc_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int SATURATE   = 0
) (
    input  logic [DATA_WIDTH-1:0] old_val,
    input  logic [DATA_WIDTH-1:0] add_val,
    input  logic                  acc,
    output logic [DATA_WIDTH-1:0] new_val
);
    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] sum;
    logic                  ovf;

    // The sum wraps mod 2^DATA_WIDTH.
    // Overflow means both operands have the same sign and the sum's sign differs from it.
    assign sum = old_val + add_val;
    assign ovf = (old_val[MSB] == add_val[MSB]) && (sum[MSB] != old_val[MSB]);

    // Choose overwrite, wrapped sum, or clamped sum.
    always_comb begin
        new_val = add_val;
        if (acc) begin
            new_val = sum;
            if ((SATURATE != 0) && ovf) new_val = old_val[MSB] ? SMIN : SMAX;
        end
    end
endmodule

module sp_stream_acc #(
    parameter int SP_NTARGETS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_WIDTH   = 64,
    parameter int SATURATE    = 0,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int TW         = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
    localparam int RW         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic                 wr_acc_i,
    input  logic [TW-1:0]        wr_target_i,
    input  logic [RW-1:0]        wr_row_i,
    input  logic [BUS_WIDTH-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [TW-1:0]        rd_target_i,
    input  logic [RW-1:0]        rd_row_i,
    output logic [BUS_WIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 str_start_i,
    input  logic [TW-1:0]        str_target_i,
    input  logic [RW:0]          str_rows_i,
    input  logic                 str_ready_i,
    output logic                 str_valid_o,
    output logic [BUS_WIDTH-1:0] str_data_o,
    output logic                 str_last_o,
    output logic                 str_busy_o
);
    // Bounds held one bit wider than the index, so comparisons against them cannot overflow.
    localparam logic [TW:0] NTGT = (TW+1)'(SP_NTARGETS);
    localparam logic [RW:0] NROW = (RW+1)'(MAX_DIM);
    localparam logic [RW:0] ONE  = (RW+1)'(1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [SP_NTARGETS-1:0][MAX_DIM-1:0][BUS_WIDTH-1:0] mem;

    // ---------------- write / accumulate path ----------------
    logic                 wr_ok;
    logic [BUS_WIDTH-1:0] wr_old;
    logic [BUS_WIDTH-1:0] wr_new;

    assign wr_ok  = wr_en_i && ({1'b0, wr_target_i} < NTGT) && ({1'b0, wr_row_i} < NROW);
    assign wr_old = mem[wr_target_i][wr_row_i];

    // One accumulator per lane. No carry crosses a lane boundary.
    for (genvar k = 0; k < MAX_DIM; k++) begin : g_lane
        sp_acc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .SATURATE   (SATURATE)
        ) u_lane (
            .old_val (wr_old[k*DATA_WIDTH +: DATA_WIDTH]),
            .add_val (wr_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .acc     (wr_acc_i),
            .new_val (wr_new[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Row storage. Back-to-back accumulates chain through the value stored on the previous edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '0;
        end else if (wr_ok) begin
            mem[wr_target_i][wr_row_i] <= wr_new;
        end
    end

    // ---------------- random read port ----------------
    logic rd_ok;
    assign rd_ok = ({1'b0, rd_target_i} < NTGT) && ({1'b0, rd_row_i} < NROW);

    // Registered read. A same-edge write is not visible; the data holds until the next request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) rd_data_o <= rd_ok ? mem[rd_target_i][rd_row_i] : '0;
        end
    end

    // ---------------- streaming engine ----------------
    state_t        state;
    logic [TW-1:0] s_tgt;
    logic [RW:0]   s_n;
    logic [RW:0]   s_cnt;
    logic [RW:0]   cnt_nxt;
    logic [RW:0]   rows_clamped;
    logic          start_ok;

    assign start_ok     = str_start_i && ({1'b0, str_target_i} < NTGT);
    assign rows_clamped = ((str_rows_i == '0) || (str_rows_i > NROW)) ? NROW : str_rows_i;
    assign cnt_nxt      = s_cnt + ONE;

    // IDLE->SEND on start, SEND->IDLE on the last accepted beat.
    // Each row is snapshotted into str_data_o on the edge that loads it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            s_tgt       <= '0;
            s_n         <= '0;
            s_cnt       <= '0;
            str_data_o  <= '0;
            str_valid_o <= 1'b0;
            str_last_o  <= 1'b0;
            str_busy_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state       <= S_SEND;
                        s_tgt       <= str_target_i;
                        s_n         <= rows_clamped;
                        s_cnt       <= '0;
                        str_data_o  <= mem[str_target_i][0];
                        str_valid_o <= 1'b1;
                        str_busy_o  <= 1'b1;
                        str_last_o  <= (rows_clamped == ONE);
                    end
                end
                S_SEND: begin
                    if (str_ready_i) begin
                        if (str_last_o) begin
                            state       <= S_IDLE;
                            str_valid_o <= 1'b0;
                            str_last_o  <= 1'b0;
                            str_busy_o  <= 1'b0;
                        end else begin
                            s_cnt      <= cnt_nxt;
                            str_data_o <= mem[s_tgt][cnt_nxt[RW-1:0]];
                            str_last_o <= (cnt_nxt == (s_n - ONE));
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_stream_acc.sv
// Bench for sp_stream_acc.
// Runs a wrap-around instance and a saturating instance side by side on the same inputs.
// Expected rows come from a lane-wise behavioural model and are queued per request.
module tb_sp_stream_acc;
    localparam int NT = 4;
    localparam int DW = 32;
    localparam int BW = 128;
    localparam int MD = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          wr_en = 1'b0, wr_acc = 1'b0;
    logic [1:0]    wr_target = '0, rd_target = '0, str_target = '0;
    logic [1:0]    wr_row = '0, rd_row = '0;
    logic [BW-1:0] wr_data = '0;
    logic          rd_en = 1'b0, str_start = 1'b0, str_ready = 1'b0;
    logic [2:0]    str_rows = '0;

    logic [BW-1:0] rd_data, rd_data_s, str_data, str_data_s;
    logic          rd_valid, rd_valid_s, str_valid, str_valid_s;
    logic          str_last, str_last_s, str_busy, str_busy_s;

    sp_stream_acc #(.SP_NTARGETS(NT), .DATA_WIDTH(DW), .BUS_WIDTH(BW), .SATURATE(0)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .wr_en_i(wr_en), .wr_acc_i(wr_acc), .wr_target_i(wr_target), .wr_row_i(wr_row), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_target_i(rd_target), .rd_row_i(rd_row), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .str_start_i(str_start), .str_target_i(str_target), .str_rows_i(str_rows), .str_ready_i(str_ready),
        .str_valid_o(str_valid), .str_data_o(str_data), .str_last_o(str_last), .str_busy_o(str_busy));

    sp_stream_acc #(.SP_NTARGETS(NT), .DATA_WIDTH(DW), .BUS_WIDTH(BW), .SATURATE(1)) dut_s (
        .clk_i(clk), .rst_ni(rst_ni),
        .wr_en_i(wr_en), .wr_acc_i(wr_acc), .wr_target_i(wr_target), .wr_row_i(wr_row), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_target_i(rd_target), .rd_row_i(rd_row), .rd_data_o(rd_data_s), .rd_valid_o(rd_valid_s),
        .str_start_i(str_start), .str_target_i(str_target), .str_rows_i(str_rows), .str_ready_i(str_ready),
        .str_valid_o(str_valid_s), .str_data_o(str_data_s), .str_last_o(str_last_s), .str_busy_o(str_busy_s));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] mdl0 [NT][MD];
    logic [BW-1:0] mdl1 [NT][MD];
    logic [BW-1:0] rd_q0 [$];
    logic [BW-1:0] rd_q1 [$];
    logic [BW-1:0] str_q [$];

    function automatic logic [BW-1:0] mdl_op(input logic [BW-1:0] old, input logic [BW-1:0] d,
                                             input bit acc, input bit sat);
        logic [BW-1:0] r;
        if (!acc) return d;
        for (int k = 0; k < MD; k++) begin
            longint s;
            s = longint'($signed(old[k*DW +: DW])) + longint'($signed(d[k*DW +: DW]));
            if (sat && s > 64'sd2147483647) s = 64'sd2147483647;
            if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
            r[k*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] row4(input logic [31:0] l3, input logic [31:0] l2,
                                           input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < MD; r++) begin
                mdl0[t][r] = '0;
                mdl1[t][r] = '0;
            end
    endtask

    task automatic mdl_apply(input int t, input int r, input logic [BW-1:0] d, input bit acc);
        mdl0[t][r] = mdl_op(mdl0[t][r], d, acc, 1'b0);
        mdl1[t][r] = mdl_op(mdl1[t][r], d, acc, 1'b1);
    endtask

    task automatic set_wr(input int t, input int r, input logic [BW-1:0] d, input bit acc);
        wr_en = 1'b1; wr_acc = acc; wr_target = 2'(t); wr_row = 2'(r); wr_data = d;
    endtask

    task automatic do_write(input int t, input int r, input logic [BW-1:0] d, input bit acc);
        set_wr(t, r, d, acc);
        tick();
        wr_en = 1'b0;
        mdl_apply(t, r, d, acc);
    endtask

    task automatic set_rd(input int t, input int r);
        rd_en = 1'b1; rd_target = 2'(t); rd_row = 2'(r);
        rd_q0.push_back(mdl0[t][r]);
        rd_q1.push_back(mdl1[t][r]);
    endtask

    task automatic test_reset();
        logic [BW-1:0] e0, e1;
        mdl_clear();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rd_valid, str_valid, str_last, str_busy} !== 4'b0 || rd_data !== '0 || str_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b sv=%b sl=%b sb=%b rd=%h sd=%h, want all 0",
                     rd_valid, str_valid, str_last, str_busy, rd_data, str_data);
        end
        rst_ni = 1'b1;
        tick();
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < MD; r++) begin
                set_rd(t, r);
                tick();
                e0 = rd_q0.pop_front();
                e1 = rd_q1.pop_front();
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== e0 || rd_valid_s !== 1'b1 || rd_data_s !== e1) begin
                    errors++;
                    $display("FAIL reset_read t%0d r%0d: got %b/%h %b/%h, want 1/%h 1/%h",
                             t, r, rd_valid, rd_data, rd_valid_s, rd_data_s, e0, e1);
                end
            end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_pulse: got %b/%b, want 0/0", rd_valid, rd_valid_s);
        end
    endtask

    task automatic test_accumulate();
        logic [BW-1:0] e0;
        do_write(1, 2, row4(4, 3, 2, 1), 1'b0);
        do_write(1, 2, row4(40, 30, 20, 10), 1'b1);
        set_rd(1, 2);
        tick();
        rd_en = 1'b0;
        e0 = rd_q0.pop_front();
        void'(rd_q1.pop_front());
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== row4(44, 33, 22, 11) || rd_data !== e0) begin
            errors++;
            $display("FAIL acc_basic: got v=%b %h, want v=1 %h", rd_valid, rd_data, row4(44, 33, 22, 11));
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== e0) begin
            errors++;
            $display("FAIL rd_hold: got v=%b %h, want v=0 %h", rd_valid, rd_data, e0);
        end
        // two back-to-back accumulates, then a read on the same edge as a third accumulate
        do_write(1, 2, row4(1, 1, 1, 1), 1'b1);
        do_write(1, 2, row4(2, 2, 2, 2), 1'b1);
        set_wr(1, 2, row4(100, 100, 100, 100), 1'b1);
        set_rd(1, 2);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        mdl_apply(1, 2, row4(100, 100, 100, 100), 1'b1);
        e0 = rd_q0.pop_front();
        void'(rd_q1.pop_front());
        checks++;
        if (rd_data !== e0 || rd_data !== row4(47, 36, 25, 14)) begin
            errors++;
            $display("FAIL acc_chain_prewrite: got %h, want %h", rd_data, row4(47, 36, 25, 14));
        end
        set_rd(1, 2);
        tick();
        rd_en = 1'b0;
        e0 = rd_q0.pop_front();
        void'(rd_q1.pop_front());
        checks++;
        if (rd_data !== e0 || rd_data !== row4(147, 136, 125, 114)) begin
            errors++;
            $display("FAIL acc_after_write: got %h, want %h", rd_data, row4(147, 136, 125, 114));
        end
    endtask

    task automatic test_saturate();
        logic [BW-1:0] e0, e1;
        do_write(0, 0, row4(32'd100, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF), 1'b0);
        do_write(0, 0, row4(32'hFFFF_FF38, 32'd1, 32'hFFFF_FFFF, 32'd1), 1'b1);
        set_rd(0, 0);
        tick();
        rd_en = 1'b0;
        e0 = rd_q0.pop_front();
        e1 = rd_q1.pop_front();
        checks++;
        if (rd_data !== e0 || rd_data[31:0] !== 32'h8000_0000 || rd_data[63:32] !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL acc_wrap: got %h, want %h", rd_data, e0);
        end
        checks++;
        if (rd_data_s !== e1 || rd_data_s[31:0] !== 32'h7FFF_FFFF || rd_data_s[63:32] !== 32'h8000_0000) begin
            errors++;
            $display("FAIL acc_sat: got %h, want %h", rd_data_s, e1);
        end
    endtask

    task automatic test_stream_stall();
        logic [BW-1:0] d, e;
        logic          v, l;
        bit   [4:0]    pat;
        pat = 5'b11001;
        for (int r = 0; r < MD; r++) do_write(2, r, row4(32'(r), 32'h2200, 32'hA5, 32'(r + 7)), 1'b0);
        str_start = 1'b1; str_target = 2'd2; str_rows = 3'd3;
        for (int r = 0; r < 3; r++) str_q.push_back(mdl0[2][r]);
        tick();
        str_start = 1'b0;
        checks++;
        if (str_valid !== 1'b1 || str_busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_start: got v=%b b=%b, want 1/1", str_valid, str_busy);
        end
        for (int i = 0; i < 5; i++) begin
            str_ready = pat[i];
            v = str_valid; d = str_data; l = str_last;
            tick();
            if (v && pat[i]) begin
                e = str_q.pop_front();
                checks++;
                if (d !== e || l !== (str_q.size() == 0)) begin
                    errors++;
                    $display("FAIL stall_beat %0d: got %h last=%b, want %h last=%b", i, d, l, e, str_q.size() == 0);
                end
            end else if (v) begin
                checks++;
                if (str_data !== d || str_last !== l || str_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold %0d: got %h last=%b v=%b, want %h last=%b v=1",
                             i, str_data, str_last, str_valid, d, l);
                end
            end
        end
        str_ready = 1'b0;
        checks++;
        if (str_busy !== 1'b0 || str_valid !== 1'b0 || str_last !== 1'b0 || str_q.size() != 0) begin
            errors++;
            $display("FAIL stall_end: got b=%b v=%b l=%b left=%0d, want 0/0/0/0",
                     str_busy, str_valid, str_last, str_q.size());
        end
    endtask

    task automatic test_stream_full();
        logic [BW-1:0] d, e, nv;
        logic          v, l;
        nv = row4(32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D);
        for (int r = 0; r < MD; r++) do_write(3, r, row4(32'h33, 32'(r), 32'h0, 32'(r * 3)), 1'b0);
        str_start = 1'b1; str_target = 2'd3; str_rows = 3'd0;
        for (int r = 0; r < MD; r++) str_q.push_back(mdl0[3][r]);
        tick();
        str_start = 1'b0;
        for (int i = 0; i < 12 && str_q.size() > 0; i++) begin
            str_ready = 1'b1;
            if (i == 0) begin
                set_wr(3, 3, nv, 1'b0);
                str_q[3] = nv;
            end
            if (i == 1) begin
                str_start = 1'b1; str_target = 2'd0; str_rows = 3'd2;
            end
            v = str_valid; d = str_data; l = str_last;
            tick();
            wr_en = 1'b0;
            str_start = 1'b0;
            if (i == 0) mdl_apply(3, 3, nv, 1'b0);
            if (v) begin
                e = str_q.pop_front();
                checks++;
                if (d !== e || l !== (str_q.size() == 0)) begin
                    errors++;
                    $display("FAIL full_beat %0d: got %h last=%b, want %h last=%b", i, d, l, e, str_q.size() == 0);
                end
            end
        end
        tick();
        str_ready = 1'b0;
        checks++;
        if (str_busy !== 1'b0 || str_valid !== 1'b0 || str_q.size() != 0) begin
            errors++;
            $display("FAIL full_end: got b=%b v=%b left=%0d, want 0/0/0", str_busy, str_valid, str_q.size());
        end
    endtask

    task automatic test_reset_abort();
        logic [BW-1:0] e0;
        str_start = 1'b1; str_target = 2'd1; str_rows = 3'd4; str_ready = 1'b0;
        tick();
        str_start = 1'b0;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (str_valid !== 1'b0 || str_busy !== 1'b0 || str_last !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: got v=%b b=%b l=%b, want 0/0/0", str_valid, str_busy, str_last);
        end
        mdl_clear();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        tick();
        checks++;
        if (str_busy !== 1'b0 || str_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_resume: got v=%b b=%b, want 0/0", str_valid, str_busy);
        end
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < MD; r++) begin
                set_rd(t, r);
                tick();
                e0 = rd_q0.pop_front();
                void'(rd_q1.pop_front());
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== e0 || rd_data_s !== '0) begin
                    errors++;
                    $display("FAIL abort_mem t%0d r%0d: got v=%b %h/%h, want 1 %h", t, r, rd_valid, rd_data, rd_data_s, e0);
                end
            end
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_accumulate();
        test_saturate();
        test_stream_stall();
        test_stream_full();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
